nmi_arbiter: RTL

Shares the single Z80 /NMI line between three requesters: magic button, DivMMC button and external expansion (Multiface-style).
- Latches requests and picks one winner.
- Aligns /NMI assertion to the frame interrupt edge and holds /NMI until the CPU fetches 0x0066.
- Grants the winner exclusive ownership until it signals done, then enforces a holdoff before the next NMI.
- Sits between the button/expansion logic and the magic/divmmc mapping blocks. Owns the only driver of the CPU /NMI pin.

---
 rtl/nmi_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/nmi_arbiter.sv
// Arbitrates the single Z80 /NMI between magic, DivMMC and expansion requesters.
// Define NMI_ARB_RR_EN for round-robin arbitration; default is fixed priority magic > divmmc > ext.
module nmi_arbiter #(
    parameter int unsigned HOLDOFF_FRAMES     = 2,
    parameter int unsigned ACK_TIMEOUT_FRAMES = 4,
    parameter int unsigned CNT_W              = 3
) (
    input  logic        rst_n,
    input  logic        clk28,
    input  logic [15:0] bus_a,
    input  logic        bus_mreq,
    input  logic        bus_m1,
    input  logic        n_int,
    input  logic        n_int_next,
    input  logic [2:0]  req,
    input  logic [2:0]  done,
    output logic        n_nmi,
    output logic [2:0]  grant,
    output logic        active
);
    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE, HOLDOFF} state_t;

    state_t           state_q, state_d;
    logic [2:0]       req_prev_q;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       grant_q, grant_d;
    logic             n_nmi_q, n_nmi_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    logic             tick, ack, launch, win_found;
    logic [1:0]       win_idx;
    logic [2:0]       req_rise, win_onehot;

    assign tick     = n_int & ~n_int_next;
    assign ack      = bus_m1 & bus_mreq & (bus_a == 16'h0066);
    assign req_rise = req & ~req_prev_q;
    assign cnt_inc  = (tick && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

`ifdef NMI_ARB_RR_EN
    logic [1:0] rr_q;
    logic [1:0] probe;

    // Search starts at the slot after the previous winner, wrapping 2 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = rr_q;
        for (int unsigned k = 0; k < 3; k++) begin
            if (!win_found && pending_q[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
            probe = (probe == 2'd2) ? 2'd0 : probe + 2'd1;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (launch) begin
            rr_q <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
        end
    end
`else
    always_comb begin
        win_found = |pending_q;
        if (pending_q[0])      win_idx = 2'd0;
        else if (pending_q[1]) win_idx = 2'd1;
        else                   win_idx = 2'd2;
    end
`endif

    assign win_onehot = 3'b001 << win_idx;
    assign launch     = (state_q == IDLE) && tick && win_found;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        n_nmi_d   = n_nmi_q;
        active_d  = active_q;
        cnt_d     = cnt_inc;
        pending_d = pending_q | req_rise;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d   = ASSERT;
                    grant_d   = win_onehot;
                    pending_d = pending_d & ~win_onehot;
                    n_nmi_d   = 1'b0;
                    active_d  = 1'b1;
                end
            end
            ASSERT: begin
                if (ack) begin
                    n_nmi_d = 1'b1;
                    state_d = SERVICE;
                end else if (cnt_inc >= CNT_W'(ACK_TIMEOUT_FRAMES)) begin
                    n_nmi_d = 1'b1;
                    grant_d = '0;
                    state_d = HOLDOFF;
                end
            end
            SERVICE: begin
                if (|(done & grant_q)) begin
                    grant_d = '0;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt_q >= CNT_W'(HOLDOFF_FRAMES)) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Every state starts its frame count from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_prev_q <= '0;
            pending_q  <= '0;
            grant_q    <= '0;
            n_nmi_q    <= 1'b1;
            active_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= req;
            pending_q  <= pending_d;
            grant_q    <= grant_d;
            n_nmi_q    <= n_nmi_d;
            active_q   <= active_d;
            cnt_q      <= cnt_d;
        end
    end

    assign n_nmi  = n_nmi_q;
    assign grant  = grant_q;
    assign active = active_q;
endmodule
